// File: rtl/bf16_fpu.sv
// Single-cycle combinational bfloat16 add/sub/mul/div with one-hot opcode select.
// Subnormals flush to zero; results are rounded to nearest, ties to even.
module bf16_fpu (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op_i,
    input  logic [15:0] in1_i,
    input  logic [15:0] in2_i,
    output logic [15:0] out_o,
    output logic        overflow_o
);

    localparam logic [15:0] QNAN = 16'h7FC0;

    // clk/rst only exist for interface uniformity; nothing here is clocked
    logic unusedClkRst;
    assign unusedClkRst = clk ^ rst;

    logic isAdd, isSub, isMul, isDiv, isAddSub;
    assign isAdd    = (op_i == 4'b0001);
    assign isSub    = (op_i == 4'b0010);
    assign isMul    = (op_i == 4'b0100);
    assign isDiv    = (op_i == 4'b1000);
    assign isAddSub = isAdd | isSub;

    logic       signA, signB, signBEff;
    logic [7:0] expA, expB, mantA, mantB;
    logic       zeroA, zeroB, infA, infB, nanA, nanB;

    assign signA    = in1_i[15];
    assign signB    = in2_i[15];
    assign signBEff = signB ^ isSub;
    assign expA     = in1_i[14:7];
    assign expB     = in2_i[14:7];
    assign zeroA    = (expA == 8'h00);
    assign zeroB    = (expB == 8'h00);
    assign infA     = (expA == 8'hFF) && (in1_i[6:0] == 7'h00);
    assign infB     = (expB == 8'hFF) && (in2_i[6:0] == 7'h00);
    assign nanA     = (expA == 8'hFF) && (in1_i[6:0] != 7'h00);
    assign nanB     = (expB == 8'hFF) && (in2_i[6:0] != 7'h00);
    assign mantA    = zeroA ? 8'h00 : {1'b1, in1_i[6:0]};
    assign mantB    = zeroB ? 8'h00 : {1'b1, in2_i[6:0]};

    function automatic logic [3:0] lzc11(input logic [10:0] v);
        lzc11 = 4'd11;
        for (int i = 0; i < 11; i++) begin
            if (v[i]) lzc11 = 4'(10 - i);
        end
    endfunction

    // mant holds 1.fffffff in [10:3] plus guard [2] and sticky [1:0]; returns {overflow, result}
    function automatic logic [16:0] roundPack(input logic sign, input logic signed [10:0] expIn,
                                              input logic [10:0] mant);
        logic              inc;
        logic [8:0]        m9;
        logic signed [10:0] e;
        logic [6:0]        frac;
        inc  = mant[2] & (mant[3] | mant[1] | mant[0]);
        m9   = {1'b0, mant[10:3]} + {8'b0, inc};
        e    = expIn + 11'(m9[8]);
        frac = m9[8] ? m9[7:1] : m9[6:0];
        if (e >= 11'sd255)
            roundPack = {1'b1, sign, 8'hFF, 7'h00};
        else if (e <= 11'sd0)
            roundPack = {1'b0, sign, 15'h0000};
        else
            roundPack = {1'b0, sign, e[7:0], frac};
    endfunction

    // Add/sub: order by magnitude so the difference never goes negative
    logic [14:0]        magA, magB;
    logic               swapOps, signL, signS;
    logic [7:0]         expL, expS, mantL, mantS, expDiff;
    logic [3:0]         shiftAmt, addLz;
    logic [23:0]        alignTmp;
    logic [10:0]        alignedS, addMant;
    logic [11:0]        sumRaw;
    logic signed [10:0] addExp;
    logic               addZero;

    always_comb begin
        magA     = zeroA ? 15'd0 : in1_i[14:0];
        magB     = zeroB ? 15'd0 : in2_i[14:0];
        swapOps  = magB > magA;
        signL    = swapOps ? signBEff : signA;
        signS    = swapOps ? signA : signBEff;
        expL     = swapOps ? expB : expA;
        expS     = swapOps ? expA : expB;
        mantL    = swapOps ? mantB : mantA;
        mantS    = swapOps ? mantA : mantB;
        expDiff  = expL - expS;
        shiftAmt = (expDiff > 8'd13) ? 4'd13 : expDiff[3:0];
        alignTmp = {mantS, 16'h0000} >> shiftAmt;
        alignedS = {alignTmp[23:14], |alignTmp[13:0]};
        if (signL == signS)
            sumRaw = {1'b0, mantL, 3'b000} + {1'b0, alignedS};
        else
            sumRaw = {1'b0, mantL, 3'b000} - {1'b0, alignedS};
        addZero = (sumRaw == 12'h000);
        addLz   = sumRaw[11] ? 4'd0 : lzc11(sumRaw[10:0]);
        if (sumRaw[11])
            addMant = {sumRaw[11:2], sumRaw[1] | sumRaw[0]};
        else
            addMant = sumRaw[10:0] << addLz;
        addExp = 11'(expL) + 11'(sumRaw[11]) - 11'(addLz);
    end

    logic [15:0]        prod;
    logic [10:0]        mulMant;
    logic signed [10:0] mulExp;

    always_comb begin
        prod = mantA * mantB;
        if (prod[15])
            mulMant = {prod[15:6], prod[5] | (|prod[4:0])};
        else
            mulMant = {prod[14:5], prod[4] | (|prod[3:0])};
        mulExp = 11'(expA) + 11'(expB) - 11'd127 + 11'(prod[15]);
    end

    // Quotient carries 11 significant bits; the remainder folds into sticky
    logic [18:0]        divNum, divDen;
    logic [11:0]        divQ;
    logic               divRemNz;
    logic [10:0]        divMant;
    logic signed [10:0] divExp;

    always_comb begin
        divNum   = {mantA, 11'h000};
        divDen   = zeroB ? 19'd1 : {11'h000, mantB};
        divQ     = 12'(divNum / divDen);
        divRemNz = (divNum % divDen) != 19'd0;
        if (divQ[11])
            divMant = {divQ[11:2], divQ[1] | divQ[0] | divRemNz};
        else
            divMant = {divQ[10:1], divQ[0] | divRemNz};
        divExp = 11'(expA) - 11'(expB) + 11'd127 - 11'(!divQ[11]);
    end

    logic signProd;
    assign signProd = signA ^ signB;

    always_comb begin
        out_o      = 16'h0000;
        overflow_o = 1'b0;
        if (!(isAddSub | isMul | isDiv)) begin
            out_o = 16'h0000;
        end else if (nanA | nanB) begin
            out_o = QNAN;
        end else if (isAddSub) begin
            if (infA & infB & (signA != signBEff))
                out_o = QNAN;
            else if (infA)
                out_o = {signA, 15'h7F80};
            else if (infB)
                out_o = {signBEff, 15'h7F80};
            else if (addZero)
                out_o = {signA & signBEff, 15'h0000};
            else
                {overflow_o, out_o} = roundPack(signL, addExp, addMant);
        end else if (isMul) begin
            if ((zeroA & infB) | (infA & zeroB))
                out_o = QNAN;
            else if (infA | infB)
                out_o = {signProd, 15'h7F80};
            else if (zeroA | zeroB)
                out_o = {signProd, 15'h0000};
            else
                {overflow_o, out_o} = roundPack(signProd, mulExp, mulMant);
        end else begin
            if ((zeroA & zeroB) | (infA & infB))
                out_o = QNAN;
            else if (infA | zeroB)
                out_o = {signProd, 15'h7F80};
            else if (infB | zeroA)
                out_o = {signProd, 15'h0000};
            else
                {overflow_o, out_o} = roundPack(signProd, divExp, divMant);
        end
    end

endmodule

// File: tb/tb_bf16_fpu.sv
// Directed-vector bench for bf16_fpu; expected results are hand-computed bf16 encodings.
module tb_bf16_fpu;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  opIn = 4'b0000;
    logic [15:0] in1 = 16'h0000;
    logic [15:0] in2 = 16'h0000;
    logic [15:0] outO;
    logic        ovfO;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    bf16_fpu dut (
        .clk        (clk),
        .rst        (rst),
        .op_i       (op_i_drv()),
        .in1_i      (in1),
        .in2_i      (in2),
        .out_o      (outO),
        .overflow_o (ovfO)
    );

    function automatic logic [3:0] op_i_drv();
        return opIn;
    endfunction

    always #5 clk = ~clk;

    // Inputs change just after the falling edge, well away from the rising edge
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        opIn = op;
        in1  = a;
        in2  = b;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] expOut, input logic expOvf);
        checkCount++;
        assert (outO === expOut && ovfO === expOvf)
            passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: got out=%h ovf=%b, expected out=%h ovf=%b",
                   tag, outO, ovfO, expOut, expOvf);
        end
    endtask

    initial begin
        applyStimulus(OP_ADD, 16'h3F80, 16'h3F80);
        checkOutput("add_during_rst", 16'h4000, 1'b0);
        repeat (2) @(posedge clk);
        rst = 1'b0;

        applyStimulus(OP_ADD, 16'h3F80, 16'h3F80); checkOutput("add_1p1", 16'h4000, 1'b0);
        applyStimulus(OP_ADD, 16'h3F80, 16'hBF80); checkOutput("add_cancel", 16'h0000, 1'b0);
        applyStimulus(OP_SUB, 16'h4040, 16'h3F80); checkOutput("sub_3m1", 16'h4000, 1'b0);
        applyStimulus(OP_SUB, 16'h3F81, 16'h3F80); checkOutput("sub_lz_norm", 16'h3C00, 1'b0);
        applyStimulus(OP_ADD, 16'h8000, 16'h8000); checkOutput("add_negzero", 16'h8000, 1'b0);
        applyStimulus(OP_ADD, 16'h3F80, 16'h3B80); checkOutput("add_tie_even", 16'h3F80, 1'b0);
        applyStimulus(OP_ADD, 16'h3F81, 16'h3B80); checkOutput("add_tie_odd", 16'h3F82, 1'b0);
        applyStimulus(OP_ADD, 16'h3FFF, 16'h3B80); checkOutput("add_rnd_carry", 16'h4000, 1'b0);
        applyStimulus(OP_ADD, 16'h0001, 16'h3F80); checkOutput("add_ftz_in", 16'h3F80, 1'b0);

        applyStimulus(OP_MUL, 16'h4000, 16'h4040); checkOutput("mul_2x3", 16'h40C0, 1'b0);
        applyStimulus(OP_MUL, 16'hC000, 16'h4040); checkOutput("mul_neg", 16'hC0C0, 1'b0);
        applyStimulus(OP_MUL, 16'h3FFF, 16'h3FFF); checkOutput("mul_norm1", 16'h407E, 1'b0);
        applyStimulus(OP_MUL, 16'h0100, 16'h3F00); checkOutput("mul_min_norm", 16'h0080, 1'b0);
        applyStimulus(OP_MUL, 16'h0080, 16'h3F00); checkOutput("mul_undflow", 16'h0000, 1'b0);
        applyStimulus(OP_MUL, 16'h0080, 16'h0080); checkOutput("mul_tiny", 16'h0000, 1'b0);

        applyStimulus(OP_DIV, 16'h3F80, 16'h4040); checkOutput("div_1by3", 16'h3EAB, 1'b0);
        applyStimulus(OP_DIV, 16'h4000, 16'h3FC0); checkOutput("div_2by1p5", 16'h3FAB, 1'b0);
        applyStimulus(OP_DIV, 16'h3F80, 16'h0000); checkOutput("div_by_zero", 16'h7F80, 1'b0);
        applyStimulus(OP_DIV, 16'hBF80, 16'h0000); checkOutput("div_neg_by0", 16'hFF80, 1'b0);
        applyStimulus(OP_DIV, 16'h3F80, 16'h7F80); checkOutput("div_by_inf", 16'h0000, 1'b0);
        applyStimulus(OP_DIV, 16'h7F80, 16'h4000); checkOutput("div_inf_num", 16'h7F80, 1'b0);
        applyStimulus(OP_DIV, 16'h0000, 16'h0000); checkOutput("div_0by0", 16'h7FC0, 1'b0);

        applyStimulus(OP_MUL, 16'h7F00, 16'h7F00); checkOutput("mul_ovf", 16'h7F80, 1'b1);
        applyStimulus(OP_ADD, 16'h7F7F, 16'h7F7F); checkOutput("add_ovf", 16'h7F80, 1'b1);
        applyStimulus(OP_ADD, 16'h7F7F, 16'h7B00); checkOutput("add_rnd_ovf", 16'h7F80, 1'b1);
        applyStimulus(OP_ADD, 16'h7F7F, 16'h7A80); checkOutput("add_max_keep", 16'h7F7F, 1'b0);

        applyStimulus(OP_ADD, 16'h7F80, 16'hFF80); checkOutput("add_inf_minf", 16'h7FC0, 1'b0);
        applyStimulus(OP_MUL, 16'h0000, 16'h7F80); checkOutput("mul_0xinf", 16'h7FC0, 1'b0);
        applyStimulus(OP_MUL, 16'h0001, 16'h7F80); checkOutput("mul_sub_inf", 16'h7FC0, 1'b0);
        applyStimulus(OP_ADD, 16'h7FC1, 16'h3F80); checkOutput("add_nan", 16'h7FC0, 1'b0);
        applyStimulus(OP_SUB, 16'h3F80, 16'h7F80); checkOutput("sub_fin_inf", 16'hFF80, 1'b0);

        applyStimulus(4'b0000, 16'h3F80, 16'h3F80); checkOutput("op_none", 16'h0000, 1'b0);
        applyStimulus(4'b0011, 16'h7F7F, 16'h7F7F); checkOutput("op_multi", 16'h0000, 1'b0);

        // Reset asserted across clock edges must not disturb the combinational result
        applyStimulus(OP_MUL, 16'h4000, 16'h4040);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_run", 16'h40C0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_released", 16'h40C0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
